// File: rtl/mini_core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mini_core_pkg : shared data_mem geometry and sequencer state type   |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
package mini_core_pkg;

  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4,
    WR   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem : 2**ADDR_W x DATA_W storage, registered dual read, 1 write|
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module data_mem
  import mini_core_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              i_enable,
  input  logic              i_read_writenot,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;

  always_ff @(posedge clk) begin
    if (i_enable) begin
      if (i_read_writenot) begin
        r_rdata1 <= r_mem[i_raddr1];
        r_rdata2 <= r_mem[i_raddr2];
      end else begin
        r_mem[i_waddr] <= i_wdata;
      end
    end
  end

  assign o_rdata1 = r_rdata1;
  assign o_rdata2 = r_rdata2;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_ctrl : load/store sequencer and zero-fill sweep for data_mem|
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module data_mem_ctrl
  import mini_core_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int DEPTH     = MEM_DEPTH,
  parameter int AUTO_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data1,
  output logic [DATA_W-1:0] resp_data2,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              mem_enable,
  output logic              mem_read_writenot,
  output logic [ADDR_W-1:0] mem_raddr1,
  output logic [ADDR_W-1:0] mem_raddr2,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata1,
  input  logic [DATA_W-1:0] mem_rdata2
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_init_pending;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data1;
  logic [DATA_W-1:0] r_resp_data2;
  logic              r_init_busy;
  logic              r_init_done;
  logic              r_mem_enable;
  logic              r_mem_rwn;
  logic [ADDR_W-1:0] r_mem_raddr1;
  logic [ADDR_W-1:0] r_mem_raddr2;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_req_ready;

  // Gated by rst so no request can slip in while reset is held.
  assign w_req_ready = rst && (r_state == IDLE) && !r_init_pending && !init_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_init_pending <= (AUTO_INIT != 0);
      r_resp_valid   <= 1'b0;
      r_resp_data1   <= '0;
      r_resp_data2   <= '0;
      r_init_busy    <= 1'b0;
      r_init_done    <= 1'b0;
      r_mem_enable   <= 1'b0;
      r_mem_rwn      <= 1'b1;
      r_mem_raddr1   <= '0;
      r_mem_raddr2   <= '0;
      r_mem_waddr    <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_init_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_init_pending || init_start) begin
            r_state        <= INIT;
            r_cnt          <= '0;
            r_init_pending <= 1'b0;
            r_init_busy    <= 1'b1;
            r_mem_enable   <= 1'b1;
            r_mem_rwn      <= 1'b0;
            r_mem_waddr    <= '0;
            r_mem_wdata    <= '0;
          end else if (req_valid) begin
            r_mem_enable <= 1'b1;
            if (req_store) begin
              r_state     <= WR;
              r_mem_rwn   <= 1'b0;
              r_mem_waddr <= req_addr1;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state      <= RD;
              r_mem_rwn    <= 1'b1;
              r_mem_raddr1 <= req_addr1;
              r_mem_raddr2 <= req_addr2;
            end
          end
        end
        INIT: begin
          if (r_cnt == c_LAST) begin
            r_state      <= IDLE;
            r_init_busy  <= 1'b0;
            r_init_done  <= 1'b1;
            r_mem_enable <= 1'b0;
            r_mem_rwn    <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_mem_waddr <= r_cnt + 1'b1;
          end
        end
        WR: begin
          r_state      <= IDLE;
          r_mem_enable <= 1'b0;
          r_mem_rwn    <= 1'b1;
        end
        RD: begin
          r_state      <= CAP;
          r_mem_enable <= 1'b0;
        end
        // Read data from data_mem is valid in this cycle.
        CAP: begin
          r_state      <= RESP;
          r_resp_data1 <= mem_rdata1;
          r_resp_data2 <= mem_rdata2;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready         = w_req_ready;
  assign resp_valid        = r_resp_valid;
  assign resp_data1        = r_resp_data1;
  assign resp_data2        = r_resp_data2;
  assign init_busy         = r_init_busy;
  assign init_done         = r_init_done;
  assign mem_enable        = r_mem_enable;
  assign mem_read_writenot = r_mem_rwn;
  assign mem_raddr1        = r_mem_raddr1;
  assign mem_raddr2        = r_mem_raddr2;
  assign mem_waddr         = r_mem_waddr;
  assign mem_wdata         = r_mem_wdata;

endmodule
`default_nettype wire
